piso_serializer: RTL and testbench

- Parallel-in serial-out stage that sits directly downstream of the PIPO register: it captures the PIPO's N-bit Q word and streams it out one bit per clock.
- Uses a valid/ready load handshake, so the producer stalls while a frame is in flight.
- Marks frame boundaries so a downstream deserializer can realign.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_bit_counter.sv | 20 ++
 rtl/piso_serializer.sv | 94 +++++++++
 tb/tb_piso_serializer.sv | 118 +++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and sizing helpers for piso_serializer; PISO_PARITY_EN adds a trailing parity bit
package piso_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int frame_len(input int n);
    return n + int'(PAR_EN);
  endfunction
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: loadable down-counter that holds at zero and flags it
module piso_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  // reload wins; otherwise count down and stop at zero
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt  = cnt_q;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: N-bit parallel-in serial-out with load handshake and frame markers; PISO_PARITY_EN appends an even-parity bit
module piso_serializer
  import piso_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Data,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         frame_start,
  output logic         frame_last
);
  localparam int CW = cnt_w(N);
  state_t         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic           sout_q, sout_d, sout_valid_q, sout_valid_d;
  logic           frame_start_q, frame_start_d, frame_last_q, frame_last_d;
  logic [CW-1:0]  cnt;
  logic           zero, acc;
  assign load_ready = !rst && (state_q == IDLE || state_q == PARITY || (state_q == SHIFT && zero && !PAR_EN));
  assign acc        = load_valid && load_ready;
  piso_bit_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (acc),
    .dec      (state_q == SHIFT),
    .load_val (CW'(N - 1)),
    .cnt      (cnt),
    .zero     (zero)
  );
`ifdef PISO_PARITY_EN
  logic par_q, par_d;
  // parity of the word captured at load
  always_comb par_d = acc ? ^Data : par_q;
  // parity register
  always_ff @(posedge clk) par_q <= rst ? 1'b0 : par_d;
`endif
  // next state and next registered outputs; outputs lead the state by one edge
  always_comb begin
    state_d       = IDLE;
    sr_d          = sr_q;
    sout_d        = 1'b0;
    sout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_last_d  = 1'b0;
    if (acc) begin
      state_d       = SHIFT;
      sr_d          = Data;
      sout_d        = MSB_FIRST ? Data[N-1] : Data[0];
      sout_valid_d  = 1'b1;
      frame_start_d = 1'b1;
    end else if (state_q == SHIFT && !zero) begin
      state_d      = SHIFT;
      sr_d         = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
      sout_d       = MSB_FIRST ? sr_q[N-2] : sr_q[1];
      sout_valid_d = 1'b1;
      frame_last_d = !PAR_EN && cnt == CW'(1);
`ifdef PISO_PARITY_EN
    end else if (state_q == SHIFT) begin
      state_d      = PARITY;
      sout_d       = par_q;
      sout_valid_d = 1'b1;
      frame_last_d = 1'b1;
`endif
    end
  end
  // state, shift register and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
    end
  end
  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign frame_last  = frame_last_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for MSB-first and LSB-first serializers driven in lockstep
module tb_piso_serializer;
  localparam int N = 4;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef struct packed {
    logic [1:0] b;
    logic       s;
    logic       l;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] data = '0;
  logic         load_valid = 1'b0;
  logic         lr[2], so[2], sv[2], fs[2], fl[2];
  exp_t         q[$];
  int           tests = 0;
  int           fails = 0;
  always #5 clk = ~clk;
  piso_serializer #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .Data(data), .load_valid(load_valid), .load_ready(lr[0]),
    .sout(so[0]), .sout_valid(sv[0]), .frame_start(fs[0]), .frame_last(fl[0])
  );
  piso_serializer #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .Data(data), .load_valid(load_valid), .load_ready(lr[1]),
    .sout(so[1]), .sout_valid(sv[1]), .frame_start(fs[1]), .frame_last(fl[1])
  );
  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask
  // monitor and reference model: outputs are checked mid-cycle, then the accept about to happen is modelled
  always @(negedge clk) begin
    exp_t e;
    logic busy;
    busy = q.size() != 0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("load_ready%0d", k), lr[k], !rst && q.size() <= 1);
      chk($sformatf("sout_valid%0d", k), sv[k], busy);
    end
    e = busy ? q.pop_front() : exp_t'('0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("sout%0d", k), so[k], e.b[k]);
      chk($sformatf("frame_start%0d", k), fs[k], e.s);
      chk($sformatf("frame_last%0d", k), fl[k], e.l);
    end
    if (rst) q.delete();
    else if (load_valid && !busy || load_valid && q.size() == 0) begin
      for (int i = 0; i < N; i++) q.push_back('{b: {data[i], data[N-1-i]}, s: i == 0, l: !PAR && i == N - 1});
      if (PAR) q.push_back('{b: {^data, ^data}, s: 1'b0, l: 1'b1});
    end
  end
  task automatic send(input logic [N-1:0] d);
    int n;
    data = d;
    load_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!lr[0] && n < 3 * N) begin
      n++;
      @(negedge clk);
    end
    if (!lr[0]) begin
      fails++;
      tests++;
      $display("FAIL send_timeout at %0t: load_ready stuck %b expected 1", $time, lr[0]);
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    data = N'($urandom);
  endtask
  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);
    send(4'b0110);
    idle(N + 3);
    send(4'b0111);
    idle(N + 3);
    send(4'b0110);
    send(4'b0111);
    idle(N + 3);
    send(4'b0110);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    send(4'b0111);
    idle(N + 3);
    for (int it = 0; it < 60; it++) begin
      send(N'($urandom));
      if ($urandom_range(0, 14) == 0) begin
        idle($urandom_range(0, N));
        rst = 1'b1;
        idle($urandom_range(1, 2));
        rst = 1'b0;
      end else idle($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, N + 2));
    end
    idle(3 * N);
    chk("drained", q.size() == 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
